// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: one-word holding buffer feeding an MSB-first
// shifter framed by an active-low strobe, with a fixed idle gap after each frame.
module p2s_tx #(
    parameter int unsigned DW  = 8,
    parameter int unsigned GAP = 4
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          din_vld,
    input  logic [DW-1:0] din,
    output logic          din_rdy,
    output logic          wra_n,
    output logic          da,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CW = $clog2(DW);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   hold_q, hold_d;
    logic            hold_vld_q, hold_vld_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]   bitcnt_q, bitcnt_d;
    logic [GW-1:0]   gapcnt_q, gapcnt_d;
    logic            wra_n_q, wra_n_d;
    logic            da_q, da_d;
    logic            done_q, done_d;
    logic            load;

    // State register; reset forces the strobe high and drops any held word.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            gapcnt_q   <= '0;
            wra_n_q    <= 1'b1;
            da_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            gapcnt_q   <= gapcnt_d;
            wra_n_q    <= wra_n_d;
            da_q       <= da_d;
            done_q     <= done_d;
        end
    end

    // Next-state: buffer accept, frame sequencing and registered line values.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        gapcnt_d   = gapcnt_q;
        wra_n_d    = wra_n_q;
        da_d       = da_q;
        done_d     = 1'b0;
        load       = 1'b0;

        // Accept and load never coincide: a full buffer holds din_rdy low.
        if (din_vld && din_rdy) begin
            hold_d     = din;
            hold_vld_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                wra_n_d = 1'b1;
                da_d    = 1'b0;
                load    = hold_vld_q;
            end
            ST_SHIFT: begin
                if (bitcnt_q != '0) begin
                    shreg_d  = shreg_q << 1;
                    da_d     = shreg_q[DW-2];
                    bitcnt_d = bitcnt_q - CW'(1);
                end else begin
                    wra_n_d  = 1'b1;
                    da_d     = 1'b0;
                    done_d   = 1'b1;
                    gapcnt_d = GW'(GAP - 1);
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                wra_n_d = 1'b1;
                da_d    = 1'b0;
                if (gapcnt_q != '0) begin
                    gapcnt_d = gapcnt_q - GW'(1);
                end else if (hold_vld_q) begin
                    load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            shreg_d    = hold_q;
            hold_vld_d = 1'b0;
            wra_n_d    = 1'b0;
            da_d       = hold_q[DW-1];
            bitcnt_d   = CW'(DW - 1);
            state_d    = ST_SHIFT;
        end
    end

    assign din_rdy = ~hold_vld_q & ~rst;
    assign busy    = (state_q != ST_IDLE) | hold_vld_q;
    assign wra_n   = wra_n_q;
    assign da      = da_q;
    assign done    = done_q;

endmodule
